// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX, EX->MEM, forwarding and data-RAM request signals of the execute stage
interface ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5,
    parameter int MEM_OP_WIDTH = 3
);
    logic                    ex_pipe_ready;
    logic                    ex_pipe_flush;
    logic                    ex_pipe_valid;
    logic [XLEN-1:0]         ex_pipe_pc;
    logic [XLEN-1:0]         ex_pipe_instruction;
    logic [3:0]              ex_pipe_alu_opcode;
    logic [3:0]              ex_pipe_md_opcode;
    logic [XLEN-1:0]         ex_pipe_op1;
    logic [XLEN-1:0]         ex_pipe_op2;
    logic [XLEN-1:0]         ex_pipe_store_data;
    logic                    ex_pipe_mem_read;
    logic                    ex_pipe_mem_write;
    logic [MEM_OP_WIDTH-1:0] ex_pipe_mem_opcode;
    logic                    ex_pipe_unsign;
    logic                    ex_pipe_rd_write;
    logic [REG_AW-1:0]       ex_pipe_rd_addr;
    logic                    mem_pipe_ready;
    logic                    mem_pipe_flush;
    logic                    mem_pipe_valid;
    logic [XLEN-1:0]         mem_pipe_pc;
    logic [XLEN-1:0]         mem_pipe_instruction;
    logic [XLEN-1:0]         mem_pipe_alu_result;
    logic                    mem_pipe_mem_read;
    logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode;
    logic                    mem_pipe_unsign;
    logic                    mem_pipe_rd_write;
    logic [REG_AW-1:0]       mem_pipe_rd_addr;
    logic                    ex_rd_write;
    logic [REG_AW-1:0]       ex_rd_addr;
    logic [XLEN-1:0]         ex_rd_wdata;
    logic                    ex_load_pending;
    logic                    dram_req;
    logic                    dram_write;
    logic [XLEN-1:0]         dram_addr;
    logic [XLEN-1:0]         dram_wdata;
    logic [3:0]              dram_wstrb;
    logic                    dram_addr_ok;

    // execute stage side
    modport slave (
        input  ex_pipe_valid, ex_pipe_pc, ex_pipe_instruction, ex_pipe_alu_opcode, ex_pipe_md_opcode,
               ex_pipe_op1, ex_pipe_op2, ex_pipe_store_data, ex_pipe_mem_read, ex_pipe_mem_write,
               ex_pipe_mem_opcode, ex_pipe_unsign, ex_pipe_rd_write, ex_pipe_rd_addr,
               mem_pipe_ready, mem_pipe_flush, dram_addr_ok,
        output ex_pipe_ready, ex_pipe_flush, mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction,
               mem_pipe_alu_result, mem_pipe_mem_read, mem_pipe_mem_opcode, mem_pipe_unsign,
               mem_pipe_rd_write, mem_pipe_rd_addr, ex_rd_write, ex_rd_addr, ex_rd_wdata,
               ex_load_pending, dram_req, dram_write, dram_addr, dram_wdata, dram_wstrb
    );

    // surrounding pipeline / memory side
    modport master (
        output ex_pipe_valid, ex_pipe_pc, ex_pipe_instruction, ex_pipe_alu_opcode, ex_pipe_md_opcode,
               ex_pipe_op1, ex_pipe_op2, ex_pipe_store_data, ex_pipe_mem_read, ex_pipe_mem_write,
               ex_pipe_mem_opcode, ex_pipe_unsign, ex_pipe_rd_write, ex_pipe_rd_addr,
               mem_pipe_ready, mem_pipe_flush, dram_addr_ok,
        input  ex_pipe_ready, ex_pipe_flush, mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction,
               mem_pipe_alu_result, mem_pipe_mem_read, mem_pipe_mem_opcode, mem_pipe_unsign,
               mem_pipe_rd_write, mem_pipe_rd_addr, ex_rd_write, ex_rd_addr, ex_rd_wdata,
               ex_load_pending, dram_req, dram_write, dram_addr, dram_wdata, dram_wstrb
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage (ALU, iterative RV32M, data-RAM request, EX->MEM register); define EX_FAST_MUL_EN for single-cycle multiplies
module ex_stage #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5,
    parameter int MEM_OP_WIDTH = 3
) (
    input logic clk,
    input logic rst,
    ex_stage_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic              r_req_sent;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_md_result;
    logic [2:0]        r_md_op;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_ex_valid, w_mem_access, w_m_op, w_fsm_op, w_result_ready;
    logic              w_ex_done, w_advance, w_dram_req;
    logic [XLEN-1:0]   w_op1, w_op2, w_alu, w_result, w_addr;
    logic [2:0]        w_md;
    logic              w_signed1, w_signed2, w_div0, w_ovf, w_ge;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_special, w_rem_dif, w_quo, w_rem, w_fixed;
    logic [XLEN:0]     w_sum, w_rem_sh;
    logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_nxt, w_prod;

    assign w_op1 = io.ex_pipe_op1;
    assign w_op2 = io.ex_pipe_op2;
    assign w_md  = io.ex_pipe_md_opcode[2:0];
    assign w_m_op = io.ex_pipe_md_opcode[3];

    assign w_ex_valid   = io.ex_pipe_valid & ~io.mem_pipe_flush;
    assign w_mem_access = io.ex_pipe_mem_read | io.ex_pipe_mem_write;

    // ALU: shifts use the low five bits of op2
    always_comb begin
        case (io.ex_pipe_alu_opcode)
            4'd0:    w_alu = w_op1 + w_op2;
            4'd1:    w_alu = w_op1 - w_op2;
            4'd2:    w_alu = w_op1 << w_op2[4:0];
            4'd3:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            4'd4:    w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            4'd5:    w_alu = w_op1 ^ w_op2;
            4'd6:    w_alu = w_op1 >> w_op2[4:0];
            4'd7:    w_alu = $signed(w_op1) >>> w_op2[4:0];
            4'd8:    w_alu = w_op1 | w_op2;
            4'd9:    w_alu = w_op1 & w_op2;
            4'd10:   w_alu = w_op2;
            default: w_alu = '0;
        endcase
    end

    // operand signedness: MULH/MULHSU/DIV/REM treat op1 as signed, MULH/DIV/REM also op2
    assign w_signed1 = (w_md == 3'd1) | (w_md == 3'd2) | (w_md[2] & ~w_md[0]);
    assign w_signed2 = (w_md == 3'd1) | (w_md[2] & ~w_md[0]);
    assign w_mag1    = (w_signed1 & w_op1[XLEN-1]) ? -w_op1 : w_op1;
    assign w_mag2    = (w_signed2 & w_op2[XLEN-1]) ? -w_op2 : w_op2;
    assign w_div0    = w_op2 == '0;
    assign w_ovf     = w_md[2] & ~w_md[0] & (w_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&w_op2);
    // divide-by-zero gives all-ones quotient and the dividend as remainder; overflow gives op1 and zero
    assign w_special = w_md[1] ? (w_div0 ? w_op1 : '0) : (w_div0 ? '1 : w_op1);

    // one shift-add multiply step: multiplier in the low half, partial product in the high half
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
    // one restoring divide step: remainder in the high half, dividend/quotient in the low half
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge      = w_rem_sh >= {1'b0, r_opnd};
    assign w_rem_dif = w_rem_sh[XLEN-1:0] - r_opnd;
    assign w_div_nxt = {w_ge ? w_rem_dif : w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
    assign w_nxt     = r_md_op[2] ? w_div_nxt : w_mul_nxt;

    // sign fixup applied to the value produced by the final iteration
    assign w_prod  = r_neg_q ? -w_nxt : w_nxt;
    assign w_quo   = r_neg_q ? -w_nxt[XLEN-1:0] : w_nxt[XLEN-1:0];
    assign w_rem   = r_neg_r ? -w_nxt[2*XLEN-1:XLEN] : w_nxt[2*XLEN-1:XLEN];
    assign w_fixed = r_md_op[2] ? (r_md_op[1] ? w_rem : w_quo)
                                : (r_md_op == 3'd0 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod;
    logic [XLEN-1:0]   w_fast;
    // low 64 bits of the 33x33 signed product of the sign/zero-extended operands
    assign w_fprod  = $signed({{XLEN{w_signed1 & w_op1[XLEN-1]}}, w_op1})
                    * $signed({{XLEN{w_signed2 & w_op2[XLEN-1]}}, w_op2});
    assign w_fast   = (w_md == 3'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    assign w_fsm_op = w_m_op & w_md[2];
    assign w_result = w_fsm_op ? r_md_result : (w_m_op ? w_fast : w_alu);
`else
    assign w_fsm_op = w_m_op;
    assign w_result = w_m_op ? r_md_result : w_alu;
`endif

    assign w_result_ready = ~w_fsm_op | (r_state == DONE);
    assign w_ex_done      = w_result_ready & (~w_mem_access | r_req_sent | io.dram_addr_ok);
    assign w_advance      = w_ex_valid & w_ex_done & io.mem_pipe_ready;
    assign w_dram_req     = w_ex_valid & w_mem_access & ~r_req_sent & io.mem_pipe_ready & ~rst;
    assign w_addr         = w_op1 + w_op2;

    assign io.ex_pipe_ready   = ~w_ex_valid | (w_ex_done & io.mem_pipe_ready);
    assign io.ex_pipe_flush   = io.mem_pipe_flush;
    assign io.ex_rd_write     = w_ex_valid & io.ex_pipe_rd_write & ~io.ex_pipe_mem_read & w_result_ready;
    assign io.ex_rd_addr      = io.ex_pipe_rd_addr;
    assign io.ex_rd_wdata     = w_result;
    assign io.ex_load_pending = io.ex_pipe_valid & io.ex_pipe_mem_read;

    assign io.dram_req   = w_dram_req;
    assign io.dram_write = io.ex_pipe_mem_write;
    assign io.dram_addr  = w_addr;
    assign io.dram_wstrb = ~io.ex_pipe_mem_write ? 4'b0000
                         : io.ex_pipe_mem_opcode[0] ? 4'b0001 << w_addr[1:0]
                         : io.ex_pipe_mem_opcode[1] ? 4'b0011 << {w_addr[1], 1'b0}
                         : {4{io.ex_pipe_mem_opcode[2]}};
    assign io.dram_wdata = io.ex_pipe_mem_opcode[0] ? {(XLEN/8){io.ex_pipe_store_data[7:0]}}
                         : io.ex_pipe_mem_opcode[1] ? {(XLEN/16){io.ex_pipe_store_data[15:0]}}
                         : io.ex_pipe_store_data;

    // multi-cycle M-op sequencer: IDLE captures operands, BUSY iterates, DONE holds the result
    always_ff @(posedge clk) begin
        if (rst || io.mem_pipe_flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_ex_valid && w_fsm_op) begin
                    r_md_op     <= w_md;
                    r_cnt       <= '0;
                    r_neg_q     <= (w_signed1 & w_op1[XLEN-1]) ^ (w_signed2 & w_op2[XLEN-1]);
                    r_neg_r     <= w_signed1 & w_op1[XLEN-1];
                    r_opnd      <= w_md[2] ? w_mag2 : w_mag1;
                    r_acc       <= {{XLEN{1'b0}}, w_md[2] ? w_mag1 : w_mag2};
                    r_md_result <= w_special;
                    r_state     <= (w_md[2] && (w_div0 || w_ovf)) ? DONE : BUSY;
                end
                BUSY: begin
                    r_acc <= w_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(XLEN-1)) begin
                        r_state     <= DONE;
                        r_md_result <= w_fixed;
                    end
                end
                DONE: if (w_advance) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // remembers an accepted request while the stage is stalled so it is never reissued
    always_ff @(posedge clk) begin
        if (rst || io.mem_pipe_flush || w_advance) r_req_sent <= 1'b0;
        else if (w_dram_req && io.dram_addr_ok) r_req_sent <= 1'b1;
    end

    // EX->MEM valid bit
    always_ff @(posedge clk) begin
        if (rst) io.mem_pipe_valid <= 1'b0;
        else if (io.mem_pipe_ready) io.mem_pipe_valid <= w_ex_valid & w_ex_done;
    end

    // EX->MEM payload, not reset
    always_ff @(posedge clk) begin
        if (io.mem_pipe_ready) begin
            io.mem_pipe_pc          <= io.ex_pipe_pc;
            io.mem_pipe_instruction <= io.ex_pipe_instruction;
            io.mem_pipe_alu_result  <= w_result;
            io.mem_pipe_mem_read    <= io.ex_pipe_mem_read;
            io.mem_pipe_mem_opcode  <= io.ex_pipe_mem_opcode;
            io.mem_pipe_unsign      <= io.ex_pipe_unsign;
            io.mem_pipe_rd_write    <= io.ex_pipe_rd_write;
            io.mem_pipe_rd_addr     <= io.ex_pipe_rd_addr;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a behavioural model
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0;
    int nerr = 0;
    int n_acc = 0;
    int acc0;

`ifdef EX_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    ex_stage_if io ();
    ex_stage dut (.clk(clk), .rst(rst), .io(io));

    // counts requests accepted by the data RAM
    always @(posedge clk) if (io.dram_req && io.dram_addr_ok) n_acc <= n_acc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        nvec++;
        assert (obs === want) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io.ex_pipe_valid = 0; io.ex_pipe_pc = '0; io.ex_pipe_instruction = '0;
        io.ex_pipe_alu_opcode = '0; io.ex_pipe_md_opcode = '0;
        io.ex_pipe_op1 = '0; io.ex_pipe_op2 = '0; io.ex_pipe_store_data = '0;
        io.ex_pipe_mem_read = 0; io.ex_pipe_mem_write = 0; io.ex_pipe_mem_opcode = '0;
        io.ex_pipe_unsign = 0; io.ex_pipe_rd_write = 0; io.ex_pipe_rd_addr = '0;
        io.mem_pipe_ready = 1; io.mem_pipe_flush = 0; io.dram_addr_ok = 0;
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint unsigned ua = a;
        int sh = int'(b % 32);
        case (op)
            4'd0: return 32'(ua + b);
            4'd1: return 32'(ua - b);
            4'd2: return 32'(ua * (64'd1 << sh));
            4'd3: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd4: return (ua < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return 32'(ua / (64'd1 << sh));
            4'd7: return 32'(sa >>> sh);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            3'd0: return 32'(ua * ub);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * longint'(ub)) >>> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int md_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] want);
        int n = 0;
        io.ex_pipe_valid = 1; io.ex_pipe_md_opcode = {1'b1, op}; io.ex_pipe_alu_opcode = '0;
        io.ex_pipe_op1 = a; io.ex_pipe_op2 = b; io.ex_pipe_rd_write = 1; io.ex_pipe_rd_addr = 5'd9;
        #1;
        if (lat > 0) chk({tag, "_wr_early"}, io.ex_rd_write, 0);
        while (!io.ex_pipe_ready && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_wdata"}, io.ex_rd_wdata, want);
        chk({tag, "_rd_write"}, io.ex_rd_write, 1);
        step();
        io.ex_pipe_valid = 0; io.ex_pipe_md_opcode = '0;
        #1;
        chk({tag, "_mem_valid"}, io.mem_pipe_valid, 1);
        chk({tag, "_mem_result"}, io.mem_pipe_alu_result, want);
    endtask

    initial begin
        logic [3:0] aop;
        logic [2:0] mop;
        logic [31:0] a, b, sd, ad, exp_data;
        logic [3:0] exp_strb;
        int sz;
        idle_inputs();
        io.ex_pipe_valid = 1; io.ex_pipe_mem_read = 1; io.ex_pipe_mem_opcode = 3'b100;
        #1;
        chk("rst_dram_req", io.dram_req, 0);
        step();
        step();
        chk("rst_mem_valid", io.mem_pipe_valid, 0);
        rst = 0;
        idle_inputs();
        #1;
        chk("idle_ready", io.ex_pipe_ready, 1);
        step();
        chk("idle_mem_valid", io.mem_pipe_valid, 0);

        io.ex_pipe_valid = 1; io.ex_pipe_op1 = 32'h7FFFFFFF; io.ex_pipe_op2 = 32'd1;
        io.ex_pipe_rd_write = 1; io.ex_pipe_rd_addr = 5'd5; io.ex_pipe_pc = 32'h100;
        #1;
        chk("add_ready", io.ex_pipe_ready, 1);
        chk("add_fwd_write", io.ex_rd_write, 1);
        chk("add_fwd_data", io.ex_rd_wdata, 32'h80000000);
        step();
        idle_inputs();
        #1;
        chk("add_mem_valid", io.mem_pipe_valid, 1);
        chk("add_mem_result", io.mem_pipe_alu_result, 32'h80000000);
        chk("add_mem_rd", io.mem_pipe_rd_addr, 5'd5);
        chk("add_mem_pc", io.mem_pipe_pc, 32'h100);

        acc0 = n_acc;
        io.ex_pipe_valid = 1; io.ex_pipe_mem_write = 1; io.ex_pipe_mem_opcode = 3'b001;
        io.ex_pipe_op1 = 32'h1000; io.ex_pipe_op2 = 32'd3; io.ex_pipe_store_data = 32'h000000A5;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sb_req_held", io.dram_req, 1);
            chk("sb_wstrb", io.dram_wstrb, 4'b1000);
            chk("sb_wdata", io.dram_wdata, 32'hA5A5A5A5);
            chk("sb_stall", io.ex_pipe_ready, 0);
            step();
        end
        io.dram_addr_ok = 1;
        #1;
        chk("sb_req_last", io.dram_req, 1);
        chk("sb_addr", io.dram_addr, 32'h1003);
        chk("sb_ready", io.ex_pipe_ready, 1);
        step();
        idle_inputs();
        #1;
        chk("sb_accepts", n_acc - acc0, 1);
        chk("sb_mem_valid", io.mem_pipe_valid, 1);
        chk("sb_req_after", io.dram_req, 0);

        acc0 = n_acc;
        io.ex_pipe_valid = 1; io.ex_pipe_mem_read = 1; io.ex_pipe_mem_opcode = 3'b100;
        io.ex_pipe_op1 = 32'h3000; io.ex_pipe_op2 = 32'd4; io.ex_pipe_rd_write = 1; io.ex_pipe_rd_addr = 5'd7;
        io.mem_pipe_ready = 0; io.dram_addr_ok = 1;
        #1;
        chk("ld_req_blocked", io.dram_req, 0);
        chk("ld_stall", io.ex_pipe_ready, 0);
        chk("ld_pending", io.ex_load_pending, 1);
        chk("ld_no_fwd", io.ex_rd_write, 0);
        step();
        io.mem_pipe_ready = 1;
        #1;
        chk("ld_req", io.dram_req, 1);
        chk("ld_ready", io.ex_pipe_ready, 1);
        chk("ld_wstrb", io.dram_wstrb, 4'b0000);
        step();
        idle_inputs();
        #1;
        chk("ld_accepts", n_acc - acc0, 1);
        chk("ld_mem_valid", io.mem_pipe_valid, 1);
        chk("ld_mem_read", io.mem_pipe_mem_read, 1);
        chk("ld_mem_addr", io.mem_pipe_alu_result, 32'h3004);

        for (int i = 0; i < 9; i++) begin
            sz = i % 3;
            ad = $urandom;
            sd = $urandom;
            io.ex_pipe_valid = 1; io.ex_pipe_mem_write = 1; io.ex_pipe_mem_opcode = 3'(1 << sz);
            io.ex_pipe_op1 = ad; io.ex_pipe_op2 = '0; io.ex_pipe_store_data = sd; io.dram_addr_ok = 1;
            exp_strb = (sz == 0) ? 4'(1 << (ad % 4)) : (sz == 1) ? ((ad % 4 >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
            exp_data = (sz == 0) ? (sd % 256) * 32'h01010101 : (sz == 1) ? (sd % 65536) * 32'h00010001 : sd;
            #1;
            chk("st_req", io.dram_req, 1);
            chk("st_wstrb", io.dram_wstrb, exp_strb);
            chk("st_wdata", io.dram_wdata, exp_data);
            step();
        end
        idle_inputs();
        step();

        run_md("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
        run_md("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
        run_md("divu_zero", 3'd5, 32'h12345678, 32'd0, 1, 32'hFFFFFFFF);
        run_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        run_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0);
        run_md("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE);

        io.ex_pipe_valid = 1; io.ex_pipe_md_opcode = 4'b1100; io.ex_pipe_op1 = 32'd100; io.ex_pipe_op2 = 32'd7;
        io.ex_pipe_rd_write = 1;
        #1;
        for (int i = 0; i < 10; i++) step();
        io.mem_pipe_flush = 1;
        #1;
        chk("fl_flush_out", io.ex_pipe_flush, 1);
        chk("fl_no_fwd", io.ex_rd_write, 0);
        step();
        idle_inputs();
        #1;
        chk("fl_mem_valid", io.mem_pipe_valid, 0);
        io.ex_pipe_valid = 1; io.ex_pipe_op1 = 32'd5; io.ex_pipe_op2 = 32'd6; io.ex_pipe_rd_write = 1;
        #1;
        chk("fl_add_ready", io.ex_pipe_ready, 1);
        chk("fl_add_data", io.ex_rd_wdata, 32'd11);
        step();
        idle_inputs();
        #1;
        chk("fl_add_valid", io.mem_pipe_valid, 1);
        chk("fl_add_result", io.mem_pipe_alu_result, 32'd11);
        run_md("fl_div_after", 3'd4, 32'd100, 32'd7, 33, 32'd14);

        for (int i = 0; i < 40; i++) begin
            aop = 4'($urandom_range(0, 10));
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            io.ex_pipe_valid = 1; io.ex_pipe_alu_opcode = aop; io.ex_pipe_op1 = a; io.ex_pipe_op2 = b;
            io.ex_pipe_rd_write = 1; io.ex_pipe_rd_addr = 5'(i);
            #1;
            chk("alu_fwd", io.ex_rd_wdata, alu_model(aop, a, b));
            step();
            chk("alu_mem", io.mem_pipe_alu_result, alu_model(aop, a, b));
        end
        idle_inputs();
        step();

        for (int i = 0; i < 16; i++) begin
            mop = 3'($urandom_range(0, 7));
            a = (i % 4 == 0) ? 32'(-$urandom_range(1, 1000)) : $urandom;
            b = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'(-$urandom_range(1, 50)) : $urandom;
            run_md("md_rand", mop, a, b, md_lat(mop, a, b), md_model(mop, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
